// File: rtl/dsd_dcache_if.sv
// Core-side and memory-side bus of the direct-mapped data cache.
// slave  : the cache's view (core requests and memory responses come in).
// master : the view of the core/memory environment driving the cache.
interface dsd_dcache_if #(
    parameter int MEM_AW = 28
);
    logic              proc_read;
    logic              proc_write;
    logic [29:0]       proc_addr;
    logic [31:0]       proc_wdata;
    logic [31:0]       proc_rdata;
    logic              proc_stall;
    logic              mem_read;
    logic              mem_write;
    logic [MEM_AW-1:0] mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dsd_dcache.sv
// Direct-mapped, write-back, write-allocate data cache with a 4-word line.
// A miss writes back a dirty victim (WB), then refills the line (ALLOC);
// the held request is then served as an ordinary hit.
// Optional hit/miss statistics are built only when DCACHE_STATS_EN is defined;
// otherwise hit_cnt/miss_cnt are tied to zero.
module dsd_dcache #(
    parameter int LINES  = 8,
    parameter int MEM_AW = 28
) (
    input  logic        clk,
    input  logic        rst,
    dsd_dcache_if.slave bus,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = MEM_AW - IDX;

    typedef enum logic [1:0] {IDLE, WB, ALLOC} state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [LINES-1:0]       dirty_q, dirty_d;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [31:0]            data_q [LINES][4];

    logic [IDX-1:0]         idx;
    logic [TAG_W-1:0]       tag;
    logic [1:0]             woff;
    logic                   req;
    logic                   hit;
    logic                   refill;
    logic                   store_hit;

    assign idx       = bus.proc_addr[IDX+1:2];
    assign tag       = bus.proc_addr[29:IDX+2];
    assign woff      = bus.proc_addr[1:0];
    assign req       = bus.proc_read | bus.proc_write;
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign refill    = (state_q == ALLOC) && bus.mem_ready;
    assign store_hit = (state_q == IDLE) && bus.proc_write && hit;

    assign bus.proc_stall = req && ((state_q != IDLE) || !hit);
    assign bus.proc_rdata = data_q[idx][woff];
    assign bus.mem_wdata  = {data_q[idx][3], data_q[idx][2], data_q[idx][1], data_q[idx][0]};

    // Next-state and memory-side request decode
    always_comb begin
        state_d       = state_q;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = {tag, idx};
        unique case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WB : ALLOC;
                end
            end
            WB: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = {tag_q[idx], idx};
                if (bus.mem_ready) state_d = ALLOC;
            end
            ALLOC: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line status next-state: a refill validates and cleans, a store hit dirties
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (refill) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end else if (store_hit) begin
            dirty_d[idx] = 1'b1;
        end
    end

    // Control state; reset abandons any memory transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays; no reset, valid bits guard their contents
    always_ff @(posedge clk) begin
        if (refill) begin
            tag_q[idx] <= tag;
            for (int k = 0; k < 4; k++) begin
                data_q[idx][k] <= bus.mem_rdata[32*k +: 32];
            end
        end else if (store_hit) begin
            data_q[idx][woff] <= bus.proc_wdata;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        missed_q, missed_d;

    // A hit following a miss of the same held request is its completion, not a new hit
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        missed_d   = missed_q;
        if ((state_q == IDLE) && req) begin
            if (hit) begin
                if (missed_q) missed_d = 1'b0;
                else          hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_d = miss_cnt_q + 32'd1;
                missed_d   = 1'b1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            missed_q   <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            missed_q   <= missed_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_dsd_dcache.sv
// Bench for dsd_dcache: directed accesses against a memory-consistency model.
// The model keeps the architectural value of every word (last store, else the
// backing memory image) and the expected hit/miss counts per access.
module tb_dsd_dcache;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    dsd_dcache_if #(.MEM_AW(28)) bus ();

    dsd_dcache #(.LINES(8), .MEM_AW(28)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] arch    [int];
    logic [31:0] mem_img [int];
    int          exp_hit  = 0;
    int          exp_miss = 0;

    // Observations of the most recent access
    logic         obs_first_stall;
    int           obs_stall_cycles;
    logic         obs_wb_seen;
    logic [27:0]  obs_wb_addr;
    logic [127:0] obs_wb_data;
    int           obs_wb_first;
    logic         obs_rd_seen;
    logic [27:0]  obs_rd_addr;
    int           obs_rd_first;
    int           obs_rd_cycles;
    logic         obs_stable;
    logic [31:0]  obs_rdata;
    logic         obs_done;

    function automatic logic [31:0] mem_word(input int a);
        return mem_img.exists(a) ? mem_img[a] : (32'h5A00_0000 | 32'(a));
    endfunction

    function automatic logic [31:0] golden(input int a);
        return arch.exists(a) ? arch[a] : mem_word(a);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_counters(input string tag);
`ifdef DCACHE_STATS_EN
        chk({tag, "_hit_cnt"}, hit_cnt, exp_hit);
        chk({tag, "_miss_cnt"}, miss_cnt, exp_miss);
`else
        chk({tag, "_hit_cnt_tied"}, hit_cnt, 0);
        chk({tag, "_miss_cnt_tied"}, miss_cnt, 0);
`endif
    endtask

    // Continuous checks against the consistency model
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.mem_read || bus.mem_write)
                chk("mem_rd_wr_exclusive", bus.mem_read & bus.mem_write, 1'b0);
            if (bus.proc_read && !bus.proc_stall)
                chk("rdata_model", bus.proc_rdata, golden(int'(bus.proc_addr)));
            if (bus.mem_write) begin
                int b;
                b = int'(bus.mem_addr) * 4;
                chk("wb_data_model", bus.mem_wdata,
                    {golden(b + 3), golden(b + 2), golden(b + 1), golden(b)});
            end
        end
    end

    // One core access, with a memory responder answering after lat waiting cycles.
    // With rst_in_wb set, a one-cycle reset is applied during the first WB cycle.
    task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] wd,
                          input int lat, input bit rst_in_wb);
        int  wcnt;
        bit  did_rst;
        obs_first_stall  = 1'b0;
        obs_stall_cycles = 0;
        obs_wb_seen      = 1'b0;
        obs_wb_addr      = '0;
        obs_wb_data      = '0;
        obs_wb_first     = -1;
        obs_rd_seen      = 1'b0;
        obs_rd_addr      = '0;
        obs_rd_first     = -1;
        obs_rd_cycles    = 0;
        obs_stable       = 1'b1;
        obs_rdata        = '0;
        obs_done         = 1'b0;
        wcnt             = 0;
        did_rst          = 1'b0;
        @(posedge clk); #1;
        bus.proc_read  = !wr;
        bus.proc_write = wr;
        bus.proc_addr  = a;
        bus.proc_wdata = wd;
        for (int cyc = 0; cyc < 200 && !obs_done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                obs_first_stall = bus.proc_stall;
                if (bus.proc_stall) exp_miss++;
                else                exp_hit++;
            end
            if (!bus.proc_stall) begin
                obs_rdata = bus.proc_rdata;
                obs_done  = 1'b1;
                @(posedge clk); #1;
                if (wr) arch[int'(a)] = wd;
                bus.proc_read  = 1'b0;
                bus.proc_write = 1'b0;
            end else begin
                obs_stall_cycles++;
                if (bus.mem_write) begin
                    if (!obs_wb_seen) begin
                        obs_wb_seen  = 1'b1;
                        obs_wb_addr  = bus.mem_addr;
                        obs_wb_data  = bus.mem_wdata;
                        obs_wb_first = cyc;
                    end else if (bus.mem_addr !== obs_wb_addr || bus.mem_wdata !== obs_wb_data) begin
                        obs_stable = 1'b0;
                    end
                    if (rst_in_wb && !did_rst) begin
                        did_rst = 1'b1;
                        @(posedge clk); #1;
                        rst = 1'b1;
                        @(posedge clk); #1;
                        rst = 1'b0;
                        arch.delete();
                        exp_hit  = 0;
                        exp_miss = 1;
                        @(negedge clk);
                        chk("rst_mid_wb_mem_write", bus.mem_write, 1'b0);
                        chk("rst_mid_wb_mem_read", bus.mem_read, 1'b0);
                        chk("rst_mid_wb_stall", bus.proc_stall, 1'b1);
                        obs_wb_seen  = 1'b0;
                        obs_wb_first = -1;
                        wcnt         = 0;
                        @(posedge clk); #1;
                        continue;
                    end
                end
                if (bus.mem_read) begin
                    obs_rd_cycles++;
                    if (!obs_rd_seen) begin
                        obs_rd_seen  = 1'b1;
                        obs_rd_addr  = bus.mem_addr;
                        obs_rd_first = cyc;
                    end else if (bus.mem_addr !== obs_rd_addr) begin
                        obs_stable = 1'b0;
                    end
                end
                if (bus.mem_read || bus.mem_write) begin
                    if (wcnt == lat) begin
                        int b;
                        b = int'(bus.mem_addr) * 4;
                        if (bus.mem_write) begin
                            for (int k = 0; k < 4; k++) mem_img[b + k] = bus.mem_wdata[32*k +: 32];
                        end else begin
                            bus.mem_rdata = {mem_word(b + 3), mem_word(b + 2), mem_word(b + 1), mem_word(b)};
                        end
                        bus.mem_ready = 1'b1;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
                @(posedge clk); #1;
                bus.mem_ready = 1'b0;
            end
        end
        chk("access_completed", obs_done, 1'b1);
        if (!obs_done) begin
            bus.proc_read  = 1'b0;
            bus.proc_write = 1'b0;
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        mem_img[4]     = 32'hCAFE_F00D;
        mem_img[5]     = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_mem_read", bus.mem_read, 1'b0);
        chk("reset_mem_write", bus.mem_write, 1'b0);
        chk("reset_stall_no_req", bus.proc_stall, 1'b0);
        chk_counters("reset");

        // Cold read miss: detect cycle + 3 ALLOC cycles, then hit
        access(1'b0, 30'h4, 32'h0, 2, 1'b0);
        chk("cold_first_stall", obs_first_stall, 1'b1);
        chk("cold_no_wb", obs_wb_seen, 1'b0);
        chk("cold_alloc_addr", obs_rd_addr, 28'h1);
        chk("cold_stall_cycles", obs_stall_cycles, 4);
        chk("cold_rdata", obs_rdata, 32'hCAFE_F00D);
        @(negedge clk);
        chk_counters("cold");

        // Read hit on neighbouring word of the refilled line
        access(1'b0, 30'h5, 32'h0, 0, 1'b0);
        chk("hit_no_stall", obs_first_stall, 1'b0);
        chk("hit_rdata", obs_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk_counters("hit");

        // Write hit dirties line 1
        access(1'b1, 30'h5, 32'h1234_5678, 0, 1'b0);
        chk("wr_hit_no_stall", obs_first_stall, 1'b0);

        // Conflicting read on index 1: dirty victim written back, then refill
        access(1'b0, 30'h24, 32'h0, 1, 1'b0);
        chk("evict_wb_seen", obs_wb_seen, 1'b1);
        chk("evict_wb_addr", obs_wb_addr, 28'h1);
        chk("evict_wb_word1", obs_wb_data[63:32], 32'h1234_5678);
        chk("evict_wb_word0", obs_wb_data[31:0], 32'hCAFE_F00D);
        chk("evict_alloc_addr", obs_rd_addr, 28'h9);
        chk("evict_wb_before_alloc", obs_wb_first < obs_rd_first, 1'b1);
        chk("evict_rdata", obs_rdata, 32'h5A00_0024);

        // Stray mem_ready while idle is ignored
        @(posedge clk); #1 bus.mem_ready = 1'b1;
        @(posedge clk); #1 bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("stray_ready_mem_read", bus.mem_read, 1'b0);
        chk("stray_ready_mem_write", bus.mem_write, 1'b0);
        access(1'b0, 30'h24, 32'h0, 0, 1'b0);
        chk("stray_ready_then_hit", obs_first_stall, 1'b0);

        // Store miss on a clean (invalid) line: refill only, then store applied
        access(1'b1, 30'h8, 32'hA5A5_A5A5, 0, 1'b0);
        chk("store_miss_stall", obs_first_stall, 1'b1);
        chk("store_miss_no_wb", obs_wb_seen, 1'b0);
        chk("store_miss_alloc_addr", obs_rd_addr, 28'h2);
        access(1'b0, 30'h8, 32'h0, 0, 1'b0);
        chk("store_miss_readback_stall", obs_first_stall, 1'b0);
        chk("store_miss_readback", obs_rdata, 32'hA5A5_A5A5);

        // Slow memory: mem_ready held low for 20 ALLOC cycles
        access(1'b0, 30'h44, 32'h0, 20, 1'b0);
        chk("slow_no_wb", obs_wb_seen, 1'b0);
        chk("slow_alloc_addr", obs_rd_addr, 28'h11);
        chk("slow_read_cycles", obs_rd_cycles, 21);
        chk("slow_stall_cycles", obs_stall_cycles, 22);
        chk("slow_stable", obs_stable, 1'b1);
        chk("slow_rdata", obs_rdata, 32'h5A00_0044);
        @(negedge clk);
        chk_counters("slow");

        // Reset during WB: dirty state lost, the held read refills without write-back
        access(1'b1, 30'h44, 32'h0BAD_C0DE, 0, 1'b0);
        chk("dirty_again_no_stall", obs_first_stall, 1'b0);
        access(1'b0, 30'h4, 32'h0, 1, 1'b1);
        chk("post_rst_no_wb", obs_wb_seen, 1'b0);
        chk("post_rst_alloc_addr", obs_rd_addr, 28'h1);
        chk("post_rst_rdata", obs_rdata, 32'hCAFE_F00D);
        @(negedge clk);
        chk_counters("post_rst");
        access(1'b0, 30'h44, 32'h0, 0, 1'b0);
        chk("lost_store_no_wb", obs_wb_seen, 1'b0);
        chk("lost_store_rdata", obs_rdata, 32'h5A00_0044);
        @(negedge clk);
        chk_counters("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
